// File: rtl/playback_ctrl_pkg.sv
// Shared constants for the playback front-panel: global mode encodings and
// the bit positions of the three panel buttons.
package playback_ctrl_pkg;

  localparam logic [2:0] MODE_IDLE   = 3'b000;
  localparam logic [2:0] MODE_CLOCK  = 3'b001;
  localparam logic [2:0] MODE_ALARM  = 3'b010;
  localparam logic [2:0] MODE_PLAY   = 3'b011;
  localparam logic [2:0] MODE_RECORD = 3'b100;

  localparam int unsigned BTN_PREV  = 0;
  localparam int unsigned BTN_PAUSE = 1;
  localparam int unsigned BTN_NEXT  = 2;
  localparam int unsigned NUM_BTN   = 3;

endpackage

// File: rtl/playback_ctrl_if.sv
// Panel/player signal bundle. The master side drives mode, buttons and player
// status; the slave side (playback_ctrl) returns pause, song index and strobe.
interface playback_ctrl_if #(
  parameter int unsigned SONG_W = 2
);

  logic [2:0]        mode;
  logic [2:0]        button;
  logic              song_end;
  logic              autoplay_en;
  logic              pause;
  logic [SONG_W-1:0] song_num;
  logic              song_change;

  modport master (
    output mode,
    output button,
    output song_end,
    output autoplay_en,
    input  pause,
    input  song_num,
    input  song_change
  );

  modport slave (
    input  mode,
    input  button,
    input  song_end,
    input  autoplay_en,
    output pause,
    output song_num,
    output song_change
  );

endinterface

// File: rtl/playback_ctrl_btn_event.sv
// One debounced button: saturating hold counter, single press pulse and an
// optional hold-to-scroll auto-repeat. The event output is registered.
module playback_ctrl_btn_event #(
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned HOLD_CYC     = 25000000,
  parameter int unsigned REPEAT_CYC   = 5000000,
  parameter bit          REPEAT_EN    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic btn,
  output logic evt
);

  localparam int unsigned CW = $clog2(HOLD_CYC + 1);
  localparam int unsigned RW = $clog2(REPEAT_CYC + 1);

  localparam logic [CW-1:0] DEB_V    = CW'(DEBOUNCE_CYC);
  localparam logic [CW-1:0] HOLD_V   = CW'(HOLD_CYC);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          evt_q, evt_d;

  always_comb begin
    cnt_d = cnt_q;
    rep_d = rep_q;
    evt_d = 1'b0;
    if (clear || !btn) begin
      cnt_d = '0;
      rep_d = '0;
    end else begin
      if (cnt_q != HOLD_V) begin
        cnt_d = cnt_q + 1'b1;
      end
      // HOLD_CYC > DEBOUNCE_CYC, so cnt_d equals DEB_V only on the step that reaches it.
      if (cnt_d == DEB_V) begin
        evt_d = 1'b1;
      end
      if (REPEAT_EN) begin
        if (cnt_q != HOLD_V && cnt_d == HOLD_V) begin
          evt_d = 1'b1;
        end else if (cnt_q == HOLD_V) begin
          if (rep_q == REP_LAST) begin
            rep_d = '0;
            evt_d = 1'b1;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      rep_q <= '0;
      evt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rep_q <= rep_d;
      evt_q <= evt_d;
    end
  end

  assign evt = evt_q;

endmodule

// File: rtl/playback_ctrl.sv
// Playback-mode front panel: debounced prev/pause/next, song index with wrap,
// pause state, end-of-song auto-advance and a one-cycle song-change strobe.
module playback_ctrl
  import playback_ctrl_pkg::*;
#(
  parameter int unsigned SONG_W       = 2,
  parameter int unsigned NUM_SONGS    = 4,
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned HOLD_CYC     = 25000000,
  parameter int unsigned REPEAT_CYC   = 5000000,
  parameter logic [2:0]  PLAY_MODE    = MODE_PLAY
) (
  input logic            clk,
  input logic            rst_n,
  playback_ctrl_if.slave bus
);

  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);

  logic active;
  logic prev_evt, pause_evt, next_evt;

  assign active = (bus.mode == PLAY_MODE);

  playback_ctrl_btn_event #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .HOLD_CYC     (HOLD_CYC),
    .REPEAT_CYC   (REPEAT_CYC),
    .REPEAT_EN    (1'b1)
  ) u_btn_prev (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!active),
    .btn   (bus.button[BTN_PREV]),
    .evt   (prev_evt)
  );

  playback_ctrl_btn_event #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .HOLD_CYC     (HOLD_CYC),
    .REPEAT_CYC   (REPEAT_CYC),
    .REPEAT_EN    (1'b0)
  ) u_btn_pause (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!active),
    .btn   (bus.button[BTN_PAUSE]),
    .evt   (pause_evt)
  );

  playback_ctrl_btn_event #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .HOLD_CYC     (HOLD_CYC),
    .REPEAT_CYC   (REPEAT_CYC),
    .REPEAT_EN    (1'b1)
  ) u_btn_next (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!active),
    .btn   (bus.button[BTN_NEXT]),
    .evt   (next_evt)
  );

  logic [SONG_W-1:0] song_q, song_d;
  logic              pause_q, pause_d;
  logic              change_q, change_d;
  logic              any_btn, end_adv, end_pause, do_next, do_prev;

  always_comb begin
    // Any button event, even a cancelled prev+next pair, swallows song_end.
    any_btn   = prev_evt | pause_evt | next_evt;
    end_adv   = bus.song_end & ~any_btn & bus.autoplay_en;
    end_pause = bus.song_end & ~any_btn & ~bus.autoplay_en;
    do_next   = (next_evt & ~prev_evt) | end_adv;
    do_prev   = prev_evt & ~next_evt;

    song_d   = song_q;
    pause_d  = pause_q;
    change_d = 1'b0;

    if (!active) begin
      song_d  = '0;
      pause_d = 1'b0;
    end else begin
      if (do_next) begin
        song_d   = (song_q == LAST_SONG) ? '0 : song_q + 1'b1;
        change_d = 1'b1;
      end else if (do_prev) begin
        song_d   = (song_q == '0) ? LAST_SONG : song_q - 1'b1;
        change_d = 1'b1;
      end

      if (change_d) begin
        pause_d = 1'b0;
      end else if (pause_evt) begin
        pause_d = ~pause_q;
      end else if (end_pause) begin
        pause_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      song_q   <= '0;
      pause_q  <= 1'b0;
      change_q <= 1'b0;
    end else begin
      song_q   <= song_d;
      pause_q  <= pause_d;
      change_q <= change_d;
    end
  end

  assign bus.song_num    = song_q;
  assign bus.pause       = pause_q;
  assign bus.song_change = change_q;

endmodule

// File: tb/tb_playback_ctrl.sv
// Directed bench for playback_ctrl with short debounce/hold/repeat timings.
module tb_playback_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   strobes;
  int   s0;

  playback_ctrl_if #(.SONG_W(2)) bus ();

  playback_ctrl #(
    .SONG_W       (2),
    .NUM_SONGS    (3),
    .DEBOUNCE_CYC (4),
    .HOLD_CYC     (10),
    .REPEAT_CYC   (3),
    .PLAY_MODE    (3'b011)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial strobes = 0;
  always @(negedge clk) begin
    if (bus.song_change === 1'b1) strobes++;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold a button pattern for five sampled edges (event + update), then release.
  task automatic press(input logic [2:0] b);
    bus.button = b;
    repeat (5) tick();
    bus.button = 3'b000;
    tick();
  endtask

  task automatic mode_clear();
    bus.mode = 3'b000;
    tick();
    bus.mode = 3'b011;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.mode = 3'b011;
    bus.button = 3'b000;
    bus.song_end = 1'b0;
    bus.autoplay_en = 1'b0;
    #12;
    check("reset_song", 32'(bus.song_num), 0);
    check("reset_pause", 32'(bus.pause), 0);
    check("reset_change", 32'(bus.song_change), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Glitch reject, then a qualifying press.
    s0 = strobes;
    bus.button = 3'b100;
    repeat (3) tick();
    bus.button = 3'b000;
    repeat (3) tick();
    check("glitch_song", 32'(bus.song_num), 0);
    check("glitch_strobes", 32'(strobes - s0), 0);
    bus.button = 3'b100;
    repeat (4) tick();
    check("deb_before", 32'(bus.song_num), 0);
    tick();
    check("deb_song", 32'(bus.song_num), 1);
    check("deb_change", 32'(bus.song_change), 1);
    bus.button = 3'b000;
    tick();
    check("deb_change_off", 32'(bus.song_change), 0);
    check("deb_strobes", 32'(strobes - s0), 1);

    // Hold-to-scroll from song 0.
    mode_clear();
    check("hold_start", 32'(bus.song_num), 0);
    s0 = strobes;
    bus.button = 3'b100;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 16) bus.button = 3'b000;
      if (k == 4)  check("hold_k4", 32'(bus.song_num), 0);
      if (k == 5)  check("hold_k5", 32'(bus.song_num), 1);
      if (k == 10) check("hold_k10", 32'(bus.song_num), 1);
      if (k == 11) check("hold_k11", 32'(bus.song_num), 2);
      if (k == 13) check("hold_k13", 32'(bus.song_num), 2);
      if (k == 14) check("hold_k14", 32'(bus.song_num), 0);
      if (k == 17) check("hold_k17", 32'(bus.song_num), 1);
    end
    check("hold_strobes", 32'(strobes - s0), 4);

    // Wrap on prev, and prev+next cancelling.
    mode_clear();
    press(3'b001);
    check("wrap_prev", 32'(bus.song_num), 2);
    s0 = strobes;
    bus.button = 3'b101;
    repeat (5) tick();
    check("both_song", 32'(bus.song_num), 2);
    check("both_strobes", 32'(strobes - s0), 0);
    bus.button = 3'b000;
    tick();

    // Pause toggling and end-of-song handling.
    press(3'b010);
    check("pause_on", 32'(bus.pause), 1);
    check("pause_song", 32'(bus.song_num), 2);
    press(3'b010);
    check("pause_off", 32'(bus.pause), 0);
    press(3'b010);
    bus.song_end = 1'b1;
    bus.autoplay_en = 1'b1;
    tick();
    bus.song_end = 1'b0;
    check("auto_song", 32'(bus.song_num), 0);
    check("auto_pause", 32'(bus.pause), 0);
    check("auto_change", 32'(bus.song_change), 1);
    bus.song_end = 1'b1;
    bus.autoplay_en = 1'b0;
    tick();
    bus.song_end = 1'b0;
    check("end_pause", 32'(bus.pause), 1);
    check("end_song", 32'(bus.song_num), 0);
    check("end_change", 32'(bus.song_change), 0);

    // Next event coincident with song_end: single step.
    bus.button = 3'b100;
    repeat (4) tick();
    bus.song_end = 1'b1;
    bus.autoplay_en = 1'b1;
    tick();
    bus.song_end = 1'b0;
    check("conf_song", 32'(bus.song_num), 1);
    check("conf_change", 32'(bus.song_change), 1);
    check("conf_pause", 32'(bus.pause), 0);
    tick();
    check("conf_song_hold", 32'(bus.song_num), 1);
    check("conf_change_off", 32'(bus.song_change), 0);
    bus.button = 3'b000;
    tick();

    // Mode exit clears state and ignores song_end.
    press(3'b100);
    press(3'b010);
    check("pre_mode_song", 32'(bus.song_num), 2);
    check("pre_mode_pause", 32'(bus.pause), 1);
    bus.mode = 3'b000;
    bus.song_end = 1'b1;
    bus.autoplay_en = 1'b0;
    tick();
    check("inact_song", 32'(bus.song_num), 0);
    check("inact_pause", 32'(bus.pause), 0);
    tick();
    check("inact_end_ignored", 32'(bus.pause), 0);
    bus.song_end = 1'b0;
    bus.mode = 3'b011;
    tick();

    // Button held across mode exit must re-qualify.
    bus.button = 3'b100;
    repeat (2) tick();
    bus.mode = 3'b000;
    tick();
    bus.mode = 3'b011;
    repeat (4) tick();
    check("reentry_wait", 32'(bus.song_num), 0);
    tick();
    check("reentry_song", 32'(bus.song_num), 1);

    // Asynchronous reset mid-hold.
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_song", 32'(bus.song_num), 0);
    check("arst_pause", 32'(bus.pause), 0);
    check("arst_change", 32'(bus.song_change), 0);
    bus.button = 3'b000;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("post_rst_song", 32'(bus.song_num), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
